mdu_ctrl: RTL

Multiply/divide unit and HI/LO scheduler for the P6 pipeline. It sits in the E stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from E and models the fixed multi-cycle latency with a down-counter. It owns the HI and LO registers and drives the D-stage stall that keeps a second MD instruction out of E while the unit is occupied. The HI/LO value it outputs travels down the pipe as `E_HI_LO` and is consumed as `in_HI_LO` in the memory stage.

---
 rtl/mdu_ctrl_pkg.sv | 28 ++
 rtl/mdu_arith.sv | 60 ++++++
 rtl/mdu_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared MD-op encodings, default latencies and FSM state type for the P6 multiply/divide unit.
// The E-stage decoder uses the same MD_* constants when it derives E_md_op.
package mdu_ctrl_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
    localparam int CNT_W          = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for mult/multu/div/divu.
// we=0 tells the controller to leave HI/LO untouched (divide by zero).
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        we
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sdiv;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] dvs_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
    assign sdiv     = (op == MD_DIV);
    assign dvd      = (sdiv && a[31]) ? -a : a;
    assign dvs      = (sdiv && b[31]) ? -b : b;
    assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    assign q_mag    = dvd / dvs_safe;
    assign r_mag    = dvd % dvs_safe;
    assign quo      = (sdiv && (a[31] ^ b[31])) ? -q_mag : q_mag;
    assign rem      = (sdiv && a[31]) ? -r_mag : r_mag;

    always_comb begin
        hi = 32'd0;
        lo = 32'd0;
        we = 1'b0;
        case (op)
            MD_MULT: begin
                {hi, lo} = prod_s;
                we       = 1'b1;
            end
            MD_MULTU: begin
                {hi, lo} = prod_u;
                we       = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                hi = rem;
                lo = quo;
                we = (b != 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: latency counter, HI/LO registers and the D-stage MD stall.
// State and counter are exposed on dbg_state/dbg_cnt for observation.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       E_md_op,
    input  logic             E_valid,
    input  logic [31:0]      E_rs_data,
    input  logic [31:0]      E_rt_data,
    input  logic             D_md_use,
    output logic             start,
    output logic             busy,
    output logic             stall_md,
    output logic [31:0]      E_HI_LO,
    output logic [31:0]      HI,
    output logic [31:0]      LO,
    output logic             dbg_state,
    output logic [CNT_W-1:0] dbg_cnt
);

    mdu_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      hi_q, hi_nxt;
    logic [31:0]      lo_q, lo_nxt;
    logic [3:0]       op_q, op_nxt;
    logic [31:0]      rs_q, rs_nxt;
    logic [31:0]      rt_q, rt_nxt;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_we;

    mdu_arith u_arith (
        .op (op_q),
        .a  (rs_q),
        .b  (rt_q),
        .hi (res_hi),
        .lo (res_lo),
        .we (res_we)
    );

    // Handshake: E offers an op with E_valid; the unit is ready when !busy, and an MD op issues
    // (start) only when both hold. stall_md holds D back from start through the last busy cycle.
    assign busy     = (state == ST_BUSY);
    assign start    = E_valid & is_muldiv(E_md_op) & ~busy;
    assign stall_md = D_md_use & (start | busy);
    assign E_HI_LO  = (E_md_op == MD_MFHI) ? hi_q : lo_q;
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign dbg_state = state;
    assign dbg_cnt   = cnt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        op_nxt    = op_q;
        rs_nxt    = rs_q;
        rt_nxt    = rt_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    op_nxt    = E_md_op;
                    rs_nxt    = E_rs_data;
                    rt_nxt    = E_rt_data;
                    cnt_nxt   = ((E_md_op == MD_MULT) || (E_md_op == MD_MULTU)) ?
                                CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_nxt = ST_BUSY;
                end else if (E_valid && (E_md_op == MD_MTHI)) begin
                    hi_nxt = E_rs_data;
                end else if (E_valid && (E_md_op == MD_MTLO)) begin
                    lo_nxt = E_rs_data;
                end
            end
            ST_BUSY: begin
                if (cnt > CNT_W'(1)) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                    if (res_we) begin
                        hi_nxt = res_hi;
                        lo_nxt = res_lo;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            op_q  <= MD_NONE;
            rs_q  <= 32'd0;
            rt_q  <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            op_q  <= op_nxt;
            rs_q  <= rs_nxt;
            rt_q  <= rt_nxt;
        end
    end

endmodule
